// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 ALU control sequencer.
// Each opcode is a mask/match pair over the full 32-bit instruction word.
package legv8_pkg;

    localparam int unsigned AluOpW = 4;

    localparam logic [AluOpW-1:0] AluIdle  = 4'd0;
    localparam logic [AluOpW-1:0] AluAnd   = 4'd1;
    localparam logic [AluOpW-1:0] AluOrr   = 4'd2;
    localparam logic [AluOpW-1:0] AluNotA  = 4'd3;
    localparam logic [AluOpW-1:0] AluPassA = 4'd4;
    localparam logic [AluOpW-1:0] AluPassB = 4'd5;
    localparam logic [AluOpW-1:0] AluAdd   = 4'd6;
    localparam logic [AluOpW-1:0] AluSub   = 4'd7;
    localparam logic [AluOpW-1:0] AluMovk  = 4'd8;

    // Field masks: [31:21], [31:23], [31:24], [31:26]
    localparam logic [31:0] Mask11 = 32'hFFE0_0000;
    localparam logic [31:0] Mask9  = 32'hFF80_0000;
    localparam logic [31:0] Mask8  = 32'hFF00_0000;
    localparam logic [31:0] Mask6  = 32'hFC00_0000;

    localparam logic [31:0] OpAdd  = {11'b10001011000, 21'd0};
    localparam logic [31:0] OpSub  = {11'b11001011000, 21'd0};
    localparam logic [31:0] OpAnd  = {11'b10001010000, 21'd0};
    localparam logic [31:0] OpOrr  = {11'b10101010000, 21'd0};
    localparam logic [31:0] OpMovk = {9'b111100101, 23'd0};
    localparam logic [31:0] OpLdur = {11'b11111000010, 21'd0};
    localparam logic [31:0] OpStur = {11'b11111000000, 21'd0};
    localparam logic [31:0] OpCbz  = {8'b10110100, 24'd0};
    localparam logic [31:0] OpB    = {6'b000101, 26'd0};

    typedef enum logic [2:0] {
        ClsR,
        ClsLoad,
        ClsStore,
        ClsCbz,
        ClsB,
        ClsIllegal
    } instr_class_e;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StExec,
        StMem,
        StWb,
        StDone
    } state_e;

    function automatic logic op_match(logic [31:0] instr, logic [31:0] mask, logic [31:0] match);
        return (instr & mask) == match;
    endfunction

endpackage

// File: rtl/legv8_alu_sequencer_if.sv
// Instruction, ALU-control and memory handshake bundle of the sequencer.
// master = sequencer side, slave = datapath/memory/fetch side.
interface legv8_alu_sequencer_if #(
    parameter int unsigned ALUOP_W = 4
);
    logic [31:0]        instruction;
    logic               instr_valid;
    logic               instr_ready;
    logic [ALUOP_W-1:0] ALUop;
    logic               alu_src_imm;
    logic               zero;
    logic               mem_read;
    logic               mem_write;
    logic               mem_ready;
    logic               mem_to_reg;
    logic               reg_write;
    logic               pc_branch;
    logic               done;
    logic               illegal;

    modport master (
        input  instruction, instr_valid, zero, mem_ready,
        output instr_ready, ALUop, alu_src_imm, mem_read, mem_write, mem_to_reg,
               reg_write, pc_branch, done, illegal
    );

    modport slave (
        output instruction, instr_valid, zero, mem_ready,
        input  instr_ready, ALUop, alu_src_imm, mem_read, mem_write, mem_to_reg,
               reg_write, pc_branch, done, illegal
    );
endinterface

// File: rtl/legv8_opcode_decode.sv
// Combinational opcode decoder: instruction word to class, ALUop and operand select.
module legv8_opcode_decode
    import legv8_pkg::*;
(
    input  logic [31:0]       instruction_i,
    output instr_class_e      cls_o,
    output logic [AluOpW-1:0] aluop_o,
    output logic              alu_src_imm_o,
    output logic              illegal_o
);

    always_comb begin
        cls_o         = ClsIllegal;
        aluop_o       = AluIdle;
        alu_src_imm_o = 1'b0;
        if (op_match(instruction_i, Mask11, OpAdd)) begin
            cls_o   = ClsR;
            aluop_o = AluAdd;
        end else if (op_match(instruction_i, Mask11, OpSub)) begin
            cls_o   = ClsR;
            aluop_o = AluSub;
        end else if (op_match(instruction_i, Mask11, OpAnd)) begin
            cls_o   = ClsR;
            aluop_o = AluAnd;
        end else if (op_match(instruction_i, Mask11, OpOrr)) begin
            cls_o   = ClsR;
            aluop_o = AluOrr;
        end else if (op_match(instruction_i, Mask9, OpMovk)) begin
            cls_o   = ClsR;
            aluop_o = AluMovk;
        end else if (op_match(instruction_i, Mask11, OpLdur)) begin
            cls_o         = ClsLoad;
            aluop_o       = AluAdd;
            alu_src_imm_o = 1'b1;
        end else if (op_match(instruction_i, Mask11, OpStur)) begin
            cls_o         = ClsStore;
            aluop_o       = AluAdd;
            alu_src_imm_o = 1'b1;
        end else if (op_match(instruction_i, Mask8, OpCbz)) begin
            cls_o   = ClsCbz;
            aluop_o = AluPassB;
        end else if (op_match(instruction_i, Mask6, OpB)) begin
            cls_o   = ClsB;
            aluop_o = AluIdle;
        end
    end

    assign illegal_o = (cls_o == ClsIllegal);

endmodule

// File: rtl/legv8_alu_sequencer.sv
// Multi-cycle LEGv8 control sequencer: one instruction per handshake, Moore outputs,
// memory accesses stall on mem_ready.
module legv8_alu_sequencer
    import legv8_pkg::*;
#(
    parameter int unsigned ALUOP_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    legv8_alu_sequencer_if.master bus_io
);

    state_e             state_q, state_d;
    logic [31:0]        instr_q, instr_d;
    instr_class_e       cls_q, cls_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic               imm_q, imm_d;
    logic               zero_q, zero_d;

    instr_class_e       dec_cls;
    logic [AluOpW-1:0]  dec_aluop;
    logic               dec_imm;
    logic               dec_illegal;

    logic               instr_ready;
    logic [ALUOP_W-1:0] aluop_out;
    logic               imm_out;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic               pc_branch;
    logic               done;
    logic               illegal;

    legv8_opcode_decode u_decode (
        .instruction_i (instr_q),
        .cls_o         (dec_cls),
        .aluop_o       (dec_aluop),
        .alu_src_imm_o (dec_imm),
        .illegal_o     (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            instr_q <= '0;
            cls_q   <= ClsIllegal;
            aluop_q <= '0;
            imm_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cls_q   <= cls_d;
            aluop_q <= aluop_d;
            imm_q   <= imm_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        cls_d       = cls_q;
        aluop_d     = aluop_q;
        imm_d       = imm_q;
        zero_d      = zero_q;
        instr_ready = 1'b0;
        aluop_out   = '0;
        imm_out     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        pc_branch   = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (bus_io.instr_valid) begin
                    instr_d = bus_io.instruction;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                cls_d   = dec_cls;
                aluop_d = ALUOP_W'(dec_aluop);
                imm_d   = dec_imm;
                state_d = dec_illegal ? StDone : StExec;
            end
            StExec: begin
                aluop_out = aluop_q;
                imm_out   = imm_q;
                zero_d    = bus_io.zero;
                case (cls_q)
                    ClsR:              state_d = StWb;
                    ClsLoad, ClsStore: state_d = StMem;
                    default:           state_d = StDone;
                endcase
            end
            StMem: begin
                // Address operands held stable until the memory accepts
                aluop_out  = aluop_q;
                imm_out    = imm_q;
                mem_read   = (cls_q == ClsLoad);
                mem_write  = (cls_q == ClsStore);
                mem_to_reg = (cls_q == ClsLoad);
                if (bus_io.mem_ready) begin
                    state_d = (cls_q == ClsLoad) ? StWb : StDone;
                end
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == ClsLoad);
                state_d    = StDone;
            end
            StDone: begin
                done      = 1'b1;
                pc_branch = (cls_q == ClsB) || ((cls_q == ClsCbz) && zero_q);
                illegal   = (cls_q == ClsIllegal);
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus_io.instr_ready = instr_ready;
    assign bus_io.ALUop       = aluop_out;
    assign bus_io.alu_src_imm = imm_out;
    assign bus_io.mem_read    = mem_read;
    assign bus_io.mem_write   = mem_write;
    assign bus_io.mem_to_reg  = mem_to_reg;
    assign bus_io.reg_write   = reg_write;
    assign bus_io.pc_branch   = pc_branch;
    assign bus_io.done        = done;
    assign bus_io.illegal     = illegal;

endmodule

// File: tb/tb_legv8_alu_sequencer.sv
// Self-checking bench: directed and randomized instructions compared per cycle against a
// timeline model built from the instruction class latencies.
module tb_legv8_alu_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    legv8_alu_sequencer_if #(.ALUOP_W(4)) bus ();

    legv8_alu_sequencer #(.ALUOP_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [12:0] ResetVec = 13'h1000;

    // {instr_ready, ALUop, alu_src_imm, mem_read, mem_write, mem_to_reg, reg_write,
    //  pc_branch, done, illegal}
    function automatic logic [12:0] out_vec();
        return {bus.instr_ready, bus.ALUop, bus.alu_src_imm, bus.mem_read, bus.mem_write,
                bus.mem_to_reg, bus.reg_write, bus.pc_branch, bus.done, bus.illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind: 0 R, 1 load, 2 store, 3 cbz, 4 b, 5 illegal
    task automatic classify(input logic [31:0] w, output int kind, output logic [3:0] op,
                            output logic imm);
        kind = 5;
        op   = 4'd0;
        imm  = 1'b0;
        if (w[31:21] == 11'b10001011000) begin kind = 0; op = 4'd6; end
        else if (w[31:21] == 11'b11001011000) begin kind = 0; op = 4'd7; end
        else if (w[31:21] == 11'b10001010000) begin kind = 0; op = 4'd1; end
        else if (w[31:21] == 11'b10101010000) begin kind = 0; op = 4'd2; end
        else if (w[31:23] == 9'b111100101) begin kind = 0; op = 4'd8; end
        else if (w[31:21] == 11'b11111000010) begin kind = 1; op = 4'd6; imm = 1'b1; end
        else if (w[31:21] == 11'b11111000000) begin kind = 2; op = 4'd6; imm = 1'b1; end
        else if (w[31:24] == 8'b10110100) begin kind = 3; op = 4'd5; end
        else if (w[31:26] == 6'b000101) begin kind = 4; op = 4'd0; end
    endtask

    function automatic int latency(input int kind, input int waits);
        case (kind)
            0:       return 4;
            1:       return 5 + waits;
            2:       return 4 + waits;
            3, 4:    return 3;
            default: return 2;
        endcase
    endfunction

    // Expected outputs c cycles after the accepting handshake
    function automatic logic [12:0] exp_vec(input int kind, input logic [3:0] op, input logic imm,
                                            input int waits, input logic z, input int c,
                                            input int lat);
        bit is_mem  = (kind == 1) || (kind == 2);
        bit in_exec = (kind != 5) && (c == 2);
        bit in_mem  = is_mem && (c >= 3) && (c <= 3 + waits);
        bit in_wb   = ((kind == 0) && (c == 3)) || ((kind == 1) && (c == 4 + waits));
        bit dn      = (c == lat);
        bit busy    = (c >= 1) && (c <= lat);
        logic [3:0] aop = (in_exec || in_mem) ? op : 4'd0;
        return {!busy, aop, (in_exec || in_mem) && imm, in_mem && (kind == 1),
                in_mem && (kind == 2), (in_mem || in_wb) && (kind == 1), in_wb,
                dn && ((kind == 4) || ((kind == 3) && z)), dn, dn && (kind == 5)};
    endfunction

    task automatic run_instr(input logic [31:0] w, input int waits, input logic z,
                             input bit hold, input string name);
        int kind;
        logic [3:0] op;
        logic imm;
        int lat;
        logic [31:0] r;
        classify(w, kind, op, imm);
        lat = latency(kind, waits);
        @(negedge clk);
        check({name, " ready"}, 32'(bus.instr_ready), 32'd1);
        r = $urandom();
        bus.instruction = w;
        bus.instr_valid = 1'b1;
        bus.zero        = r[1];
        bus.mem_ready   = r[2];
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            check($sformatf("%s c%0d", name, c), 32'(out_vec()),
                  32'(exp_vec(kind, op, imm, waits, z, c, lat)));
            r = $urandom();
            bus.instr_valid = hold ? 1'b1 : r[0];
            bus.instruction = $urandom();
            bus.zero        = (c == 2) ? z : r[1];
            if (((kind == 1) || (kind == 2)) && (c >= 3)) bus.mem_ready = (c == 3 + waits);
            else bus.mem_ready = r[2];
        end
    endtask

    logic [31:0] base_t [10];
    logic [31:0] free_t [10];

    initial begin
        logic [31:0] r;
        logic [31:0] w;
        int sel;
        base_t = '{32'h8B00_0000, 32'hCB00_0000, 32'h8A00_0000, 32'hAA00_0000, 32'hF280_0000,
                   32'hF840_0000, 32'hF800_0000, 32'hB400_0000, 32'h1400_0000, 32'h0000_0000};
        free_t = '{32'h001F_FFFF, 32'h001F_FFFF, 32'h001F_FFFF, 32'h001F_FFFF, 32'h007F_FFFF,
                   32'h001F_FFFF, 32'h001F_FFFF, 32'h00FF_FFFF, 32'h03FF_FFFF, 32'hFFFF_FFFF};

        bus.instruction = '0;
        bus.instr_valid = 1'b0;
        bus.zero        = 1'b0;
        bus.mem_ready   = 1'b0;

        // Reset values while held and after release
        @(negedge clk);
        check("reset held", 32'(out_vec()), 32'(ResetVec));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset released", 32'(out_vec()), 32'(ResetVec));

        run_instr(32'h8B030041, 0, 1'b0, 1'b0, "add");
        run_instr(32'hCB030041, 0, 1'b0, 1'b0, "sub");
        // Valid held high with new words during the busy load; only the first runs
        run_instr(32'hF8408041, 3, 1'b0, 1'b1, "ldur_w3_hold");
        run_instr(32'h8A030041, 0, 1'b0, 1'b0, "and_after_hold");
        run_instr(32'hB4000081, 0, 1'b1, 1'b0, "cbz_taken");
        run_instr(32'hB4000081, 0, 1'b0, 1'b0, "cbz_not_taken");
        run_instr(32'hF2824681, 0, 1'b0, 1'b0, "movk");
        run_instr(32'hFFFFFFFF, 0, 1'b0, 1'b0, "illegal");
        run_instr(32'h14000010, 0, 1'b0, 1'b0, "b");
        run_instr(32'hF8008041, 0, 1'b0, 1'b0, "stur_w0");
        run_instr(32'hF8008041, 2, 1'b0, 1'b0, "stur_w2");
        run_instr(32'hF8408041, 0, 1'b0, 1'b0, "ldur_w0");

        // Reset asserted during write-back
        @(negedge clk);
        check("rstwb ready", 32'(bus.instr_ready), 32'd1);
        bus.instruction = 32'h8B030041;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstwb in wb", 32'(out_vec()), 32'(exp_vec(0, 4'd6, 1'b0, 0, 1'b0, 3, 4)));
        #1 rst_n = 1'b0;
        #1 check("rstwb immediate", 32'(out_vec()), 32'(ResetVec));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rstwb after %0d", i), 32'(out_vec()), 32'(ResetVec));
        end

        for (int n = 0; n < 40; n++) begin
            r   = $urandom();
            sel = $urandom_range(0, 9);
            w   = (base_t[sel] & ~free_t[sel]) | (r & free_t[sel]);
            run_instr(w, $urandom_range(0, 3), r[0] ^ r[7], 1'b0, $sformatf("rand%0d", n));
        end

        @(negedge clk);
        bus.instr_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/legv8_alu_sequencer.md
# legv8_alu_sequencer

Multi-cycle control sequencer that drives the datapath ALU from the instruction side. It accepts one LEGv8 instruction per valid/ready handshake and decodes it into an ALUop, operand select and memory/write-back strobes. It samples the ALU `zero` flag to resolve CBZ, and signals completion with `done`. It replaces the single-cycle combinational control path so that memory accesses can stall on a ready handshake.

## Interface
- `ALUOP_W`, 4: ALUop width; matches the ALU's `ALUop` input.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instruction`  in  32  instruction word, qualified by `instr_valid`.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `ALUop`  out  ALUOP_W  operation code to the ALU.
- `alu_src_imm`  out  1  1 = ALU B operand is the sign-extended immediate; 0 = Reg2Data.
- `zero`  in  1  ALU zero flag.
- `mem_read`  out  1  load request, held until `mem_ready`.
- `mem_write`  out  1  store request, held until `mem_ready`.
- `mem_ready`  in  1  memory completes the access this cycle.
- `mem_to_reg`  out  1  write-back source is memory, not ALU_Out.
- `reg_write`  out  1  register file write strobe, 1 cycle.
- `pc_branch`  out  1  next PC is the branch target; valid while `done`=1.
- `done`  out  1  instruction retired, 1-cycle pulse.
- `illegal`  out  1  unrecognised opcode; valid while `done`=1.

## Operation
- ALUop encoding:
  - 0: idle
  - 1: AND
  - 2: ORR
  - 3: NOT A
  - 4: pass A
  - 5: pass B
  - 6: ADD
  - 7: SUB
  - 8: MOVK
- Opcode decode:
  - ADD `[31:21]`=10001011000 → R class, ALUop 6.
  - SUB `[31:21]`=11001011000 → R class, ALUop 7.
  - AND `[31:21]`=10001010000 → R class, ALUop 1.
  - ORR `[31:21]`=10101010000 → R class, ALUop 2.
  - MOVK `[31:23]`=111100101 → R class, ALUop 8.
  - LDUR `[31:21]`=11111000010 → load class, ALUop 6, imm.
  - STUR `[31:21]`=11111000000 → store class, ALUop 6, imm.
  - CBZ `[31:24]`=10110100 → cond-branch class, ALUop 5.
  - B `[31:26]`=000101 → branch class, ALUop 0.
  - Anything else → illegal.
- FSM states and transitions:
  - IDLE: `instr_ready`=1. On `instr_valid`, capture the instruction → DECODE.
  - DECODE: register the class, ALUop and `alu_src_imm`. Illegal → DONE with `illegal`=1.
  - EXEC: drive the registered ALUop. Sample `zero` on the exiting edge.
    - R → WB.
    - Load/store → MEM.
    - CBZ/B → DONE.
  - MEM: hold `mem_read` (load) or `mem_write` (store); `mem_to_reg`=1 for load. On `mem_ready`: load → WB, store → DONE.
  - WB: `reg_write`=1 (`mem_to_reg`=1 for load) → DONE.
  - DONE: `done`=1, `pc_branch` = (B) or (CBZ and sampled zero). → IDLE.
- All outputs are Moore decodes of the state and registered class. ALUop and `alu_src_imm` are non-zero only in EXEC and MEM; the address must stay stable through MEM.
- Instruction is captured only on IDLE & `instr_valid`; changes elsewhere are ignored.

## Timing
- Reset (async, any state) → IDLE. Outputs during and after reset:
  - `instr_ready`=1
  - `ALUop`=0
  - `alu_src_imm`=0
  - `mem_read`=0, `mem_write`=0
  - `mem_to_reg`=0
  - `reg_write`=0
  - `pc_branch`=0
  - `done`=0
  - `illegal`=0
- Reset mid-MEM drops `mem_read`/`mem_write` immediately; no write-back occurs.
- Handshake at cycle 0; cycles counted from there:
  - R: EXEC c2, WB c3, `done` c4, ready again c5.
  - Load with `mem_ready` in its first MEM cycle: EXEC c2, MEM c3, WB c4, `done` c5. Each extra wait cycle adds 1.
  - Store: `done` c4 + waits.
  - CBZ/B: `done` c3.
  - Illegal: `done` c2.
- `mem_ready` outside MEM is ignored. `mem_ready` high on MEM entry completes in 1 cycle.
- `zero` is sampled only at the end of EXEC; later changes do not affect `pc_branch`.

## Structure
- Package `legv8_pkg`:
  - opcode constants and masks
  - ALUop localparams 0–8
  - instruction-class enum
  - FSM state enum
- Sub-module `legv8_opcode_decode`: combinational, `instruction` → {class, ALUop, `alu_src_imm`, illegal}. Registered in DECODE by the sequencer.

## Test plan
- Reset asserted in WB → all outputs at reset values within the same cycle; `instr_ready`=1 after release; no `reg_write`.
- 0x8B030041 (ADD X1,X2,X3) → `ALUop`=6 in c2, `reg_write`=1 in c3, `done` c4; repeat with 0xCB030041 → `ALUop`=7.
- 0xF8408041 (LDUR X1,[X2,#8]), `mem_ready` delayed 3 cycles → `ALUop`=6 and `alu_src_imm`=1 held through MEM; `mem_read` high 4 cycles; `reg_write`+`mem_to_reg` one cycle; `done` c8.
- 0xB4000081 (CBZ X1,#4): `zero`=1 in EXEC → `pc_branch`=1 at `done` c3; `zero`=0 → `pc_branch`=0; `zero` toggled after EXEC has no effect.
- 0xF2824681 (MOVK X1,#0x1234) → `ALUop`=8, `reg_write`; 0xFFFFFFFF → `illegal`=1, `done` c2, no strobes.
- `instr_valid` held high with new words during a busy load → only the first word executes; the second is accepted at the IDLE cycle after `done`.
